// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx among NUM_REQUESTERS byte sources.
// Supports multi-byte packet locks with an idle-stall timeout that drops the lock.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned LOCK_TIMEOUT   = 64
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_REQUESTERS-1:0]     req_valid_i,
  input  logic [8*NUM_REQUESTERS-1:0]   req_data_i,
  input  logic [NUM_REQUESTERS-1:0]     req_last_i,
  output logic [NUM_REQUESTERS-1:0]     req_ready_o,
  output logic [NUM_REQUESTERS-1:0]     grant_o,
  output logic                          locked_o,
  output logic                          tx_write_o,
  output logic [7:0]                    tx_data_o,
  input  logic                          tx_busy_i
);

  localparam int unsigned IdxW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_REQUESTERS - 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(LOCK_TIMEOUT);
  localparam logic [CntW-1:0] CntExpire = CntW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StBusy} state_e;

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           owner_q, owner_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic                      locked_q, locked_d;
  logic                      last_q, last_d;
  logic [7:0]                data_q, data_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic                      owner_valid;
  logic                      lock_expire;
  logic                      lock_active;
  logic                      sel_found;
  logic [IdxW-1:0]           sel_idx;
  logic [7:0]                sel_data;
  logic                      sel_last;
  int unsigned               idx;

  assign owner_valid = req_valid_i[owner_q];

  // The cycle the counter would reach LOCK_TIMEOUT already counts as unlocked, so a
  // waiting requester is accepted on the same edge that drops locked_o.
  assign lock_expire = locked_q && (state_q == StIdle) && !tx_busy_i && !owner_valid &&
                       (cnt_q >= CntExpire);
  assign lock_active = locked_q && !lock_expire;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    if (lock_active) begin
      sel_found = owner_valid;
      sel_idx   = owner_q;
    end else begin
      // Search starts one past the most recent owner.
      for (int unsigned i = 1; i <= NUM_REQUESTERS; i++) begin
        idx = 32'(owner_q) + i;
        if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
        if (!sel_found && req_valid_i[IdxW'(idx)]) begin
          sel_found = 1'b1;
          sel_idx   = IdxW'(idx);
        end
      end
    end
  end

  always_comb begin
    sel_data = 8'h00;
    sel_last = 1'b0;
    for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
      if (sel_idx == IdxW'(k)) begin
        sel_data = req_data_i[8*k +: 8];
        sel_last = req_last_i[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    locked_d    = locked_q;
    last_d      = last_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    tx_write_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (owner_valid) begin
          cnt_d = '0;
        end else if (locked_q && !tx_busy_i && cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!tx_busy_i) begin
          if (lock_expire) locked_d = 1'b0;
          if (sel_found) begin
            req_ready_o[sel_idx] = 1'b1;
            data_d               = sel_data;
            last_d               = sel_last;
            owner_d              = sel_idx;
            grant_d              = '0;
            grant_d[sel_idx]     = 1'b1;
            state_d              = StWrite;
          end
        end
      end
      StWrite: begin
        tx_write_o = 1'b1;
        if (tx_busy_i) state_d = StBusy;
      end
      StBusy: begin
        if (!tx_busy_i) begin
          state_d  = StIdle;
          locked_d = ~last_q;
          cnt_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      owner_q  <= LastIdx;
      grant_q  <= '0;
      locked_q <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= 8'h00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant_o   = grant_q;
  assign locked_o  = locked_q;
  assign tx_data_o = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed cycle-by-cycle bench for uart_tx_arbiter (4 requesters, lock timeout 8).
// tx_busy_i is driven directly from the vectors in place of a UartTx instance.
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        locked;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic        tx_busy;

  int n_vec;
  int n_miss;

  uart_tx_arbiter #(
    .NUM_REQUESTERS(4),
    .LOCK_TIMEOUT  (8)
  ) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .grant_o    (grant),
    .locked_o   (locked),
    .tx_write_o (tx_write),
    .tx_data_o  (tx_data),
    .tx_busy_i  (tx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        busy;
    logic [3:0]  e_ready;
    logic [3:0]  e_grant;
    logic        e_locked;
    logic        e_write;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic rst, input logic [3:0] valid,
                     input logic [31:0] data, input logic [3:0] last, input logic busy,
                     input logic [3:0] e_ready, input logic [3:0] e_grant,
                     input logic e_locked, input logic e_write, input logic [7:0] e_data);
    vec_t v;
    v.name = name; v.rst = rst; v.valid = valid; v.data = data; v.last = last;
    v.busy = busy; v.e_ready = e_ready; v.e_grant = e_grant; v.e_locked = e_locked;
    v.e_write = e_write; v.e_data = e_data;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s: got 'h%0h, expected 'h%0h", name, field, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] e_ready,
                            input logic [3:0] e_grant, input logic e_locked,
                            input logic e_write, input logic [7:0] e_data);
    n_vec++;
    chk(name, "ready",  32'(req_ready), 32'(e_ready));
    chk(name, "grant",  32'(grant),     32'(e_grant));
    chk(name, "locked", 32'(locked),    32'(e_locked));
    chk(name, "write",  32'(tx_write),  32'(e_write));
    chk(name, "data",   32'(tx_data),   32'(e_data));
  endtask

  // Inputs change on the falling edge; outputs are sampled 3 time units later,
  // well before the next rising edge.
  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic b);
    @(negedge clock);
    reset = r; req_valid = v; req_data = d; req_last = l; tx_busy = b;
    #3;
  endtask

  localparam logic [31:0] DS  = 32'h0000_0055;
  localparam logic [31:0] DRR = 32'h00C3_B2A1;

  initial begin
    n_vec = 0; n_miss = 0;
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b1;

    // name            rst valid    data          last     busy  ready    grant    lk wr data
    add("rst",          1, 4'b0000, DS,           4'b0000, 1,   4'b0000, 4'b0000, 0, 0, 8'h00);
    add("busy_out_rst", 0, 4'b0001, DS,           4'b0001, 1,   4'b0000, 4'b0000, 0, 0, 8'h00);
    add("accept0",      0, 4'b0001, DS,           4'b0001, 0,   4'b0001, 4'b0000, 0, 0, 8'h00);
    add("write_wait0",  0, 4'b0000, DS,           4'b0001, 0,   4'b0000, 4'b0001, 0, 1, 8'h55);
    add("write_wait1",  0, 4'b0000, DS,           4'b0001, 0,   4'b0000, 4'b0001, 0, 1, 8'h55);
    add("write_busy",   0, 4'b0000, DS,           4'b0001, 1,   4'b0000, 4'b0001, 0, 1, 8'h55);
    add("busy",         0, 4'b0000, DS,           4'b0001, 1,   4'b0000, 4'b0001, 0, 0, 8'h55);
    add("busy_fall",    0, 4'b0000, DS,           4'b0001, 0,   4'b0000, 4'b0001, 0, 0, 8'h55);
    add("idle",         0, 4'b0000, DS,           4'b0001, 0,   4'b0000, 4'b0001, 0, 0, 8'h55);
    add("rst_async",    1, 4'b0000, DRR,          4'b0111, 0,   4'b0000, 4'b0000, 0, 0, 8'h00);
    add("rr0",          0, 4'b0111, DRR,          4'b0111, 0,   4'b0001, 4'b0000, 0, 0, 8'h00);
    add("rr0_wr",       0, 4'b0110, DRR,          4'b0111, 1,   4'b0000, 4'b0001, 0, 1, 8'hA1);
    add("rr0_busy",     0, 4'b0110, DRR,          4'b0111, 0,   4'b0000, 4'b0001, 0, 0, 8'hA1);
    add("rr1",          0, 4'b0110, DRR,          4'b0111, 0,   4'b0010, 4'b0001, 0, 0, 8'hA1);
    add("rr1_wr",       0, 4'b0100, DRR,          4'b0111, 1,   4'b0000, 4'b0010, 0, 1, 8'hB2);
    add("rr1_busy",     0, 4'b0100, DRR,          4'b0111, 0,   4'b0000, 4'b0010, 0, 0, 8'hB2);
    add("rr2",          0, 4'b0100, DRR,          4'b0111, 0,   4'b0100, 4'b0010, 0, 0, 8'hB2);
    add("rr2_wr",       0, 4'b0000, DRR,          4'b0111, 1,   4'b0000, 4'b0100, 0, 1, 8'hC3);
    add("rr2_busy",     0, 4'b0000, DRR,          4'b0111, 0,   4'b0000, 4'b0100, 0, 0, 8'hC3);
    add("rr_wrap0",     0, 4'b0101, DRR,          4'b0101, 0,   4'b0001, 4'b0100, 0, 0, 8'hC3);
    add("wrap_wr",      0, 4'b0100, DRR,          4'b0101, 1,   4'b0000, 4'b0001, 0, 1, 8'hA1);
    add("wrap_busy",    0, 4'b0100, DRR,          4'b0101, 0,   4'b0000, 4'b0001, 0, 0, 8'hA1);
    add("rr_then2",     0, 4'b0100, DRR,          4'b0101, 0,   4'b0100, 4'b0001, 0, 0, 8'hA1);
    add("rr2b_wr",      0, 4'b0000, DRR,          4'b0101, 1,   4'b0000, 4'b0100, 0, 1, 8'hC3);
    add("rr2b_busy",    0, 4'b0000, DRR,          4'b0101, 0,   4'b0000, 4'b0100, 0, 0, 8'hC3);
    add("pkt_b0",       0, 4'b0010, 32'h0000_10A1, 4'b0001, 0,  4'b0010, 4'b0100, 0, 0, 8'hC3);
    add("pkt_b0_wr",    0, 4'b0011, 32'h0000_11A1, 4'b0001, 1,  4'b0000, 4'b0010, 0, 1, 8'h10);
    add("pkt_b0_busy",  0, 4'b0011, 32'h0000_11A1, 4'b0001, 0,  4'b0000, 4'b0010, 0, 0, 8'h10);
    add("pkt_b1",       0, 4'b0011, 32'h0000_11A1, 4'b0001, 0,  4'b0010, 4'b0010, 1, 0, 8'h10);
    add("pkt_b1_wr",    0, 4'b0011, 32'h0000_12A1, 4'b0011, 1,  4'b0000, 4'b0010, 1, 1, 8'h11);
    add("pkt_b1_busy",  0, 4'b0011, 32'h0000_12A1, 4'b0011, 0,  4'b0000, 4'b0010, 1, 0, 8'h11);
    add("pkt_b2",       0, 4'b0011, 32'h0000_12A1, 4'b0011, 0,  4'b0010, 4'b0010, 1, 0, 8'h11);
    add("pkt_b2_wr",    0, 4'b0001, 32'h0000_12A1, 4'b0011, 1,  4'b0000, 4'b0010, 1, 1, 8'h12);
    add("pkt_b2_busy",  0, 4'b0001, 32'h0000_12A1, 4'b0011, 0,  4'b0000, 4'b0010, 1, 0, 8'h12);
    add("pkt_then0",    0, 4'b0001, 32'h0000_12A1, 4'b0011, 0,  4'b0001, 4'b0010, 0, 0, 8'h12);
    add("r0_wr",        0, 4'b0000, 32'h0000_12A1, 4'b0011, 1,  4'b0000, 4'b0001, 0, 1, 8'hA1);
    add("r0_busy",      0, 4'b0000, 32'h0000_12A1, 4'b0011, 0,  4'b0000, 4'b0001, 0, 0, 8'hA1);
    add("quiet",        0, 4'b0000, 32'h0000_12A1, 4'b0011, 0,  4'b0000, 4'b0001, 0, 0, 8'hA1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].busy);
      expect_out(tbl[i].name, tbl[i].e_ready, tbl[i].e_grant, tbl[i].e_locked,
                 tbl[i].e_write, tbl[i].e_data);
    end

    // Lock timeout: requester 2 opens a packet then stalls; requester 3 waits.
    drive(0, 4'b0100, 32'h3020_0000, 4'b1000, 0);
    expect_out("to_accept2", 4'b0100, 4'b0001, 0, 0, 8'hA1);
    drive(0, 4'b1000, 32'h3020_0000, 4'b1000, 1);
    expect_out("to_wr2", 4'b0000, 4'b0100, 0, 1, 8'h20);
    drive(0, 4'b1000, 32'h3020_0000, 4'b1000, 0);
    expect_out("to_busy2", 4'b0000, 4'b0100, 0, 0, 8'h20);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 4'b1000, 32'h3020_0000, 4'b1000, 0);
      expect_out($sformatf("to_idle%0d", i), (i == 8) ? 4'b1000 : 4'b0000, 4'b0100, 1, 0,
                 8'h20);
    end
    drive(0, 4'b0000, 32'h3020_0000, 4'b1000, 1);
    expect_out("to_wr3", 4'b0000, 4'b1000, 0, 1, 8'h30);
    drive(0, 4'b0000, 32'h3020_0000, 4'b1000, 0);
    expect_out("to_busy3", 4'b0000, 4'b1000, 0, 0, 8'h30);
    drive(0, 4'b0000, 32'h3020_0000, 4'b1000, 0);
    expect_out("to_done", 4'b0000, 4'b1000, 0, 0, 8'h30);

    // Owner returns on the expiry cycle: its byte wins and the lock survives.
    drive(0, 4'b0100, 32'h3021_0000, 4'b1000, 0);
    expect_out("kp_accept2", 4'b0100, 4'b1000, 0, 0, 8'h30);
    drive(0, 4'b1000, 32'h3021_0000, 4'b1000, 1);
    expect_out("kp_wr2", 4'b0000, 4'b0100, 0, 1, 8'h21);
    drive(0, 4'b1000, 32'h3021_0000, 4'b1000, 0);
    expect_out("kp_busy2", 4'b0000, 4'b0100, 0, 0, 8'h21);
    for (int i = 1; i <= 7; i++) begin
      drive(0, 4'b1000, 32'h3021_0000, 4'b1000, 0);
      expect_out($sformatf("kp_idle%0d", i), 4'b0000, 4'b0100, 1, 0, 8'h21);
    end
    drive(0, 4'b1100, 32'h3022_0000, 4'b1100, 0);
    expect_out("kp_idle8", 4'b0100, 4'b0100, 1, 0, 8'h21);
    drive(0, 4'b1000, 32'h3022_0000, 4'b1100, 1);
    expect_out("kp_wr22", 4'b0000, 4'b0100, 1, 1, 8'h22);
    drive(0, 4'b1000, 32'h3022_0000, 4'b1100, 0);
    expect_out("kp_busy22", 4'b0000, 4'b0100, 1, 0, 8'h22);
    drive(0, 4'b1000, 32'h3022_0000, 4'b1100, 0);
    expect_out("kp_then3", 4'b1000, 4'b0100, 0, 0, 8'h22);
    drive(0, 4'b0000, 32'h3022_0000, 4'b1100, 1);
    expect_out("kp_wr3", 4'b0000, 4'b1000, 0, 1, 8'h30);
    drive(0, 4'b0000, 32'h3022_0000, 4'b1100, 0);
    expect_out("kp_busy3", 4'b0000, 4'b1000, 0, 0, 8'h30);

    // Stalled UART: busy never rises, write holds and nobody else is served.
    drive(0, 4'b0001, 32'h0000_0044, 4'b0001, 0);
    expect_out("st_accept0", 4'b0001, 4'b1000, 0, 0, 8'h30);
    for (int i = 0; i < 20; i++) begin
      drive(0, 4'b1110, 32'h0000_0044, 4'b0001, 0);
      expect_out($sformatf("st_hold%0d", i), 4'b0000, 4'b0001, 0, 1, 8'h44);
    end
    drive(0, 4'b0000, 32'h0000_0044, 4'b0001, 1);
    expect_out("st_wr", 4'b0000, 4'b0001, 0, 1, 8'h44);
    drive(0, 4'b0000, 32'h0000_0044, 4'b0001, 0);
    expect_out("st_busy", 4'b0000, 4'b0001, 0, 0, 8'h44);

    // Reset asserted mid-cycle while in BUSY.
    drive(0, 4'b0010, 32'h0000_6600, 4'b0010, 0);
    expect_out("rm_accept1", 4'b0010, 4'b0001, 0, 0, 8'h44);
    drive(0, 4'b0000, 32'h0000_6600, 4'b0010, 1);
    expect_out("rm_wr", 4'b0000, 4'b0010, 0, 1, 8'h66);
    drive(0, 4'b0000, 32'h0000_6600, 4'b0010, 1);
    expect_out("rm_busy", 4'b0000, 4'b0010, 0, 0, 8'h66);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 expect_out("rm_async", 4'b0000, 4'b0000, 0, 0, 8'h00);
    drive(1, 4'b0000, 32'h0000_6677, 4'b0011, 1);
    expect_out("rm_hold", 4'b0000, 4'b0000, 0, 0, 8'h00);
    drive(0, 4'b0011, 32'h0000_6677, 4'b0011, 0);
    expect_out("rm_first0", 4'b0001, 4'b0000, 0, 0, 8'h00);
    drive(0, 4'b0010, 32'h0000_6677, 4'b0011, 1);
    expect_out("rm_wr0", 4'b0000, 4'b0001, 0, 1, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UartTx transmitter among NUM_REQUESTERS byte sources. It accepts bytes over a valid/ready handshake, sequences the UartTx write/busy handshake for each byte, and supports multi-byte packets: an owner holds the grant until its last byte. A lock timeout releases the grant if the owner stalls. It sits between the requesting logic and UartTx, which it drives through write_i/data_i and monitors through busy_o.

## Interface
- NUM_REQUESTERS, 4, number of byte sources; legal range 2..8.
- LOCK_TIMEOUT, 64, idle cycles a locked owner may stall before the lock is dropped; legal range 1..65535.
- clock_i  input  1  system clock; all state changes on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  NUM_REQUESTERS  per-requester byte valid.
- req_data_i  input  8*NUM_REQUESTERS  byte k occupies bits [8k+7:8k].
- req_last_i  input  NUM_REQUESTERS  per-requester end-of-packet flag, qualified by valid.
- req_ready_o  output  NUM_REQUESTERS  one-hot accept strobe; a byte transfers when valid & ready.
- grant_o  output  NUM_REQUESTERS  one-hot current or most recent owner; zero after reset.
- locked_o  output  1  owner holds a packet lock.
- tx_write_o  output  1  to UartTx write_i.
- tx_data_o  output  8  to UartTx data_i; registered.
- tx_busy_i  input  1  from UartTx busy_o.

## Operation
- FSM states: IDLE, WRITE, BUSY.
- IDLE, arbitration:
  - If tx_busy_i = 1, stay and assert no ready. This covers the busy pulse UartTx drives out of reset.
  - If locked_o = 1, only the owner is eligible.
  - Otherwise, round-robin among asserted valids, starting at (last owner + 1) mod N. After reset the last owner is N-1, so requester 0 has highest priority.
- IDLE, accept:
  - On selection of requester k, req_ready_o[k] = 1 combinationally in that cycle.
  - On the clock edge: tx_data_o <= req_data_i[k]; grant_o <= one-hot k; the last flag is captured; state -> WRITE.
- WRITE:
  - tx_write_o = 1.
  - Hold until tx_busy_i = 1, then -> BUSY. No timeout.
- BUSY:
  - tx_write_o = 0.
  - When tx_busy_i = 0, -> IDLE.
  - At that edge: locked_o <= ~captured last flag; the lock counter clears.
- Lock timeout:
  - In IDLE with locked_o = 1, tx_busy_i = 0 and the owner's valid low, a counter increments each cycle.
  - When the counter reaches LOCK_TIMEOUT, locked_o <= 0 and normal round-robin resumes, still starting after the owner.
  - The owner asserting valid clears the counter.
- Counter width is clog2(LOCK_TIMEOUT+1); the counter saturates and never wraps.
- req_ready_o is zero in WRITE and BUSY. Non-selected requesters see ready = 0 and must hold valid and data.
- Simultaneous events:
  - The owner's valid arriving in the same cycle as the timeout expiring wins: the byte is accepted and the lock is kept.
  - A single byte with last = 1 never sets the lock.

## Timing
- Reset values: state IDLE, tx_write_o 0, tx_data_o 8'h00, req_ready_o 0, grant_o 0, locked_o 0, lock counter 0, last owner N-1.
- Reset mid-operation returns to IDLE immediately. The in-flight byte is dropped and no ready is reissued for it.
- Valid to ready latency is 0 cycles when in IDLE, tx_busy_i = 0 and the requester is eligible.
- tx_write_o rises one cycle after accept and stays high until the first cycle tx_busy_i is sampled high. It falls on the edge that enters BUSY.
- Back-to-back overhead is 1 cycle in IDLE after busy falls, plus WRITE duration. A queued requester's ready asserts the cycle after the BUSY -> IDLE edge.
- Outputs do not depend on tx_busy_i combinationally, except req_ready_o in IDLE.

## Test plan
- Reset then single byte: hold reset_i high 1 cycle with UartTx (clock_divider 4) connected. Requester 0 sends 8'h55, last = 1.
  - No ready until busy_o falls after reset.
  - ready[0] pulses once; tx_write_o is high until busy rises.
  - Serial frame matches 0x55; locked_o stays 0.
- Round-robin: requesters 0, 1 and 2 all valid with 8'hA1, 8'hB2, 8'hC3, last = 1.
  - Bytes go out in order 0, 1, 2.
  - Next contention between 0 and 2 grants 0, since the last owner was 2.
- Packet lock: requester 1 sends 3 bytes 8'h10, 8'h11, 8'h12, last on the third, while requester 0 stays valid.
  - All 3 bytes from requester 1 go out before any from requester 0; locked_o is high between bytes.
- Lock timeout: LOCK_TIMEOUT = 8. Requester 2 sends 8'h20 with last = 0, then drops valid; requester 3 is valid with 8'h30.
  - locked_o falls exactly 8 idle cycles after busy falls.
  - Requester 3 is accepted in that same cycle.
  - A variant where requester 2 re-asserts valid on cycle 8 keeps the lock.
- Reset mid-frame: assert reset_i while in BUSY.
  - All outputs return to reset values asynchronously.
  - The next accept after reset is requester 0 if it is valid.
- Stalled UART: tx_busy_i forced low after accept.
  - tx_write_o stays high, no further ready is issued, and grant_o holds.
